// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared word width and loader state encoding for the Hack RAM front ends
package hack_mem_pkg;
  localparam int WORD_WIDTH = 16;
  localparam logic [2:0] LOADER_IDLE  = 3'd0;
  localparam logic [2:0] LOADER_HIGH  = 3'd1;
  localparam logic [2:0] LOADER_LOW   = 3'd2;
  localparam logic [2:0] LOADER_WRITE = 3'd3;
  localparam logic [2:0] LOADER_DONE  = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE  = LOADER_IDLE,
    S_HIGH  = LOADER_HIGH,
    S_LOW   = LOADER_LOW,
    S_WRITE = LOADER_WRITE,
    S_DONE  = LOADER_DONE
  } loader_state_t;
endpackage

// File: rtl/ram_loader_counter16.sv
// counter16: Hack-style 16-bit counter with clear > load > increment priority
module counter16
  import hack_mem_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic                  i_inc,
  input  logic [WORD_WIDTH-1:0] i_in,
  output logic [WORD_WIDTH-1:0] o_out
);
  logic [WORD_WIDTH-1:0] r_out;
  // count register; clear wins over load, load wins over increment
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_out <= '0;
    else r_out <= i_clear ? '0 : i_load ? i_in : i_inc ? r_out + WORD_WIDTH'(1) : r_out;
  assign o_out = r_out;
endmodule

// File: rtl/ram_loader.sv
// ram_loader: assembles big-endian words from a byte stream and writes them into Hack RAM
module ram_loader #(
  parameter int ADDR_WIDTH = 3,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [15:0]           load_length,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WORD_WIDTH-1:0] mem_in,
  output logic                  mem_load,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           words_written
);
  import hack_mem_pkg::*;
  loader_state_t         r_state;
  logic                  r_ready;
  logic                  r_load;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_in;
  logic [15:0]           r_len;
  logic [15:0]           w_count;
  logic                  w_clear;
  logic                  w_inc;
  assign w_clear = (r_state == S_IDLE) && start;
  assign w_inc   = (r_state == S_WRITE);
  counter16 u_count (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_clear (w_clear),
    .i_load  (1'b0),
    .i_inc   (w_inc),
    .i_in    ('0),
    .o_out   (w_count)
  );
  // loader FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_in    <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (start) begin
            r_addr  <= start_address;
            r_len   <= load_length;
            r_busy  <= 1'b1;
            r_state <= (load_length == 16'd0) ? S_DONE : S_HIGH;
            r_done  <= (load_length == 16'd0);
            r_ready <= (load_length != 16'd0);
          end
        S_HIGH:
          if (byte_valid) begin
            r_in[WORD_WIDTH-1 -: 8] <= byte_in;
            r_state <= S_LOW;
          end
        S_LOW:
          if (byte_valid) begin
            r_in[7:0] <= byte_in;
            r_ready   <= 1'b0;
            r_load    <= 1'b1;
            r_state   <= S_WRITE;
          end
        S_WRITE: begin
          r_load  <= 1'b0;
          r_addr  <= r_addr + ADDR_WIDTH'(1);
          r_state <= (w_count + 16'd1 == r_len) ? S_DONE : S_HIGH;
          r_done  <= (w_count + 16'd1 == r_len);
          r_ready <= (w_count + 16'd1 != r_len);
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_load  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  assign byte_ready    = r_ready;
  assign mem_address   = r_addr;
  assign mem_in        = r_in;
  assign mem_load      = r_load;
  assign busy          = r_busy;
  assign done          = r_done;
  assign words_written = w_count;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed and random loads checked against a write scoreboard and RAM model
module tb_ram_loader;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [2:0]  start_address = '0;
  logic [15:0] load_length = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_ready, mem_load, busy, done;
  logic [2:0]  mem_address;
  logic [15:0] mem_in, words_written;
  int          n_cmp = 0, n_err = 0, n_load = 0, n_done = 0, exp_done = 0;
  int          l0, e0, a, len;
  logic [15:0] d;
  logic [18:0] q[$];
  logic [18:0] e;
  logic [15:0] ram_m[8];
  logic [15:0] exp_ram[8];
  ram_loader #(.ADDR_WIDTH(3), .WORD_WIDTH(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .start_address (start_address),
    .load_length   (load_length),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .mem_address   (mem_address),
    .mem_in        (mem_in),
    .mem_load      (mem_load),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask
  // RAM model and write scoreboard, sampled mid-cycle
  always @(negedge clock) begin
    if (done === 1'b1) begin
      n_done++;
      chk("ready_in_done", 32'(byte_ready), 32'd0);
    end
    if (mem_load === 1'b1) begin
      n_load++;
      ram_m[mem_address] = mem_in;
      chk("ready_in_write", 32'(byte_ready), 32'd0);
      if (q.size() == 0) chk("sb_extra_write", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        chk("sb_addr", 32'(mem_address), 32'(e[18:16]));
        chk("sb_data", 32'(mem_in), 32'(e[15:0]));
      end
    end
  end
  task automatic push_word(input logic [2:0] ad, input logic [15:0] dt);
    q.push_back({ad, dt});
    exp_ram[ad] = dt;
  endtask
  task automatic do_start(input logic [2:0] ad, input logic [15:0] ln);
    start = 1'b1;
    start_address = ad;
    load_length = ln;
    @(posedge clock); #1;
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    byte_valid = 1'b1;
    byte_in = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      ok = byte_ready;
      @(posedge clock); #1;
    end
    byte_valid = 1'b0;
    if (!ok) chk("ready_timeout", 32'(byte_ready), 32'd1);
  endtask
  task automatic wait_done(input int ww, input int ad);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      seen = done;
    end
    if (!seen) chk("done_timeout", 32'(done), 32'd1);
    else begin
      chk("done_ww", 32'(words_written), 32'(ww));
      chk("done_addr", 32'(mem_address), 32'(ad));
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_noload", 32'(mem_load), 32'd0);
    end
    exp_done++;
    @(posedge clock); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("done_count", 32'(n_done), 32'(exp_done));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 8; i++) begin ram_m[i] = '0; exp_ram[i] = '0; end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_load", 32'(mem_load), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_in", 32'(mem_in), 32'd0);
    chk("rst_ww", 32'(words_written), 32'd0);
    do_start(3'd0, 16'd2);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_ready", 32'(byte_ready), 32'd1);
    push_word(3'd0, 16'h1234);
    push_word(3'd1, 16'hABCD);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    wait_done(2, 2);
    chk("basic_ram0", 32'(ram_m[0]), 32'h1234);
    chk("basic_ram1", 32'(ram_m[1]), 32'hABCD);
    do_start(3'd6, 16'd4);
    for (int w = 0; w < 4; w++) begin
      push_word(3'(6 + w), 16'(w + 1));
      send_byte(8'h00, 0);
      send_byte(8'(w + 1), 0);
    end
    wait_done(4, 2);
    chk("wrap_ram7", 32'(ram_m[7]), 32'd2);
    chk("wrap_ram0", 32'(ram_m[0]), 32'd3);
    do_start(3'd3, 16'd1);
    push_word(3'd3, 16'hBEEF);
    send_byte(8'hBE, 0);
    l0 = n_load;
    repeat (5) begin @(posedge clock); #1; end
    chk("stall_no_load", 32'(n_load), 32'(l0));
    chk("stall_ready", 32'(byte_ready), 32'd1);
    send_byte(8'hEF, 0);
    wait_done(1, 4);
    chk("stall_loads", 32'(n_load), 32'(l0 + 1));
    chk("stall_ram3", 32'(ram_m[3]), 32'hBEEF);
    l0 = n_load;
    do_start(3'd5, 16'd0);
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_busy", 32'(busy), 32'd1);
    wait_done(0, 5);
    chk("zl_no_load", 32'(n_load), 32'(l0));
    do_start(3'd0, 16'd3);
    push_word(3'd0, 16'h0A0B);
    push_word(3'd1, 16'h0C0D);
    push_word(3'd2, 16'h0E0F);
    send_byte(8'h0A, 0);
    start = 1'b1;
    start_address = 3'd4;
    load_length = 16'd1;
    send_byte(8'h0B, 0);
    start = 1'b0;
    send_byte(8'h0C, 0);
    send_byte(8'h0D, 0);
    send_byte(8'h0E, 0);
    send_byte(8'h0F, 0);
    wait_done(3, 3);
    do_start(3'd0, 16'd2);
    push_word(3'd0, 16'h1111);
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_load", 32'(mem_load), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(byte_ready), 32'd0);
    chk("arst_ww", 32'(words_written), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    chk("arst_ram0", 32'(ram_m[0]), 32'h1111);
    chk("arst_sb_empty", 32'(q.size()), 32'd0);
    do_start(3'd2, 16'd1);
    push_word(3'd2, 16'h5A5A);
    send_byte(8'h5A, 0);
    send_byte(8'h5A, 0);
    wait_done(1, 3);
    e0 = n_err;
    for (int it = 0; it < 100; it++) begin
      a = $urandom_range(0, 7);
      len = $urandom_range(1, 12);
      do_start(3'(a), 16'(len));
      for (int w = 0; w < len; w++) begin
        d = 16'($urandom);
        push_word(3'(a + w), d);
        send_byte(d[15:8], $urandom_range(0, 2));
        send_byte(d[7:0], $urandom_range(0, 2));
      end
      wait_done(len, (a + len) % 8);
    end
    for (int i = 0; i < 8; i++) chk("ram_final", 32'(ram_m[i]), 32'(exp_ram[i]));
    chk("sb_leftover", 32'(q.size()), 32'd0);
    chk("done_vs_start", 32'(n_done), 32'(exp_done));
    if (n_err == e0) $display("random test OK");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Writer-side front end for the Hack RAM blocks (ram8 and larger).
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit words.
- Drives the RAM write port (address, in, load) to store `load_length` words from `start_address` upward.
- Used to preload data/program images into RAM before the CPU is released from reset.

Parameters:
- ADDR_WIDTH, 3, width of RAM address; depth = 2^ADDR_WIDTH (3 matches ram8).
- WORD_WIDTH, 16, Hack word width; fixed at 16, exposed for clarity only.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; forces IDLE immediately.
- start  input  1  begin a load when in IDLE; ignored otherwise.
- start_address  input  ADDR_WIDTH  first RAM address, sampled on accepted start.
- load_length  input  16  number of words to write, sampled on accepted start.
- byte_in  input  8  incoming byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_address  output  ADDR_WIDTH  to RAM address.
- mem_in  output  16  to RAM in.
- mem_load  output  1  to RAM load; one-cycle write strobe.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  one-cycle pulse when the load completes.
- words_written  output  16  count of words written in the current or last load.

Behaviour:
- Reset values, applied asynchronously:
  - state = IDLE
  - byte_ready, mem_load, busy, done = 0
  - mem_address, mem_in, words_written = 0
- States are IDLE, HIGH, LOW, WRITE, DONE.
- IDLE:
  - start=1 latches start_address and load_length and clears words_written.
  - Next state is HIGH, or DONE if load_length==0 (no writes performed).
- HIGH:
  - byte_ready=1.
  - On byte_valid&&byte_ready at posedge, mem_in[15:8] = byte_in; next state LOW.
- LOW:
  - byte_ready=1.
  - On handshake, mem_in[7:0] = byte_in; next state WRITE.
- WRITE:
  - mem_load=1 for exactly this one cycle.
  - mem_address and mem_in are stable for the whole cycle.
  - byte_ready=0.
  - At the posedge ending WRITE:
    - words_written increments.
    - mem_address increments modulo 2^ADDR_WIDTH (7 wraps to 0).
    - Next state is DONE if words_written+1 == load_length, else HIGH.
- DONE:
  - done=1 for one cycle; busy stays 1.
  - Next state IDLE.
  - mem_address and words_written hold their final values.
- busy = (state != IDLE).
- Outside WRITE, mem_load=0 under all conditions.
- Latency and throughput:
  - The word is committed to RAM on the posedge ending WRITE, i.e. the 2nd posedge after the low byte is accepted.
  - Best-case throughput is 1 word per 3 cycles.
- Stalls: byte_valid low in HIGH/LOW holds state indefinitely. No timeout.
- byte_valid while in IDLE, WRITE, or DONE: byte is not accepted (byte_ready=0) and is not consumed.
- start while busy: ignored, no relatch.
- load_length > depth: writes continue past the wrap and overwrite from address 0 onward. This is legal and intended.
- Reset mid-load:
  - mem_load drops at once.
  - A partially assembled word is discarded.
  - Already-written words remain in RAM; RAM is not cleared.
- Output timing: all outputs are registered or decoded from state only. There is no combinational path from byte_valid to mem_load.

Decomposition:
- Shared package hack_mem_pkg holds:
  - WORD_WIDTH = 16
  - state encoding constants LOADER_IDLE, LOADER_HIGH, LOADER_LOW, LOADER_WRITE, LOADER_DONE (3-bit)
- words_written reuses the existing counter16 sub-module:
  - reset = accepted start
  - increment = WRITE state
  - load = 0
- mem_address is a local ADDR_WIDTH-bit register with load (on start) and increment (on WRITE).
- No other sub-modules.

Test Plan:
- Basic load: start_address=0, load_length=2, bytes 12 34 AB CD back-to-back.
  - Expect mem_load pulses with (addr 0, 16'h1234) then (addr 1, 16'hABCD).
  - done pulses once; words_written=2.
  - ram8 reads back 1234/ABCD.
- Wrap-around: start_address=6, load_length=4, bytes 00 01 00 02 00 03 00 04.
  - Expect writes at addresses 6, 7, 0, 1 with values 1, 2, 3, 4.
  - Final mem_address=2.
- Stalls: byte_valid toggled off for 5 cycles between the high and low bytes.
  - Expect no mem_load during the stall and the correct word 16'hBEEF written.
  - Exactly one mem_load per word; byte_ready=0 during WRITE and DONE.
- Zero length and busy start: load_length=0.
  - Expect done pulse 1 cycle after start, no mem_load, busy high for 1 cycle.
  - Re-asserting start during a 3-word load does not change start_address or length.
- Async reset mid-load: assert reset between the high and low byte of word 2, off-edge (e.g. at #3 after posedge).
  - Expect mem_load=0, busy=0, byte_ready=0 immediately.
  - RAM address 0 retains word 1.
  - Post-reset start loads cleanly.
- Randomized: 100 iterations of random start_address, load_length 1..12, and random bytes.
  - Expect RAM contents to match a model modulo wrap.
  - done count equals start count; bench prints OK.
